// File: rtl/dac_gain_ramp_ctrl_if.sv
// Gain-request and DAC-controller handshake bundle for dac_gain_ramp_ctrl.
// The slave modport is the ramp controller; master is the requester/DAC side.
interface dac_gain_ramp_ctrl_if #(
   parameter int GAIN_WIDTH  = 8,
   parameter int STEP_WIDTH  = 8,
   parameter int DWELL_WIDTH = 16
);
   logic [GAIN_WIDTH-1:0]  target_gain;
   logic [STEP_WIDTH-1:0]  step_size;
   logic [DWELL_WIDTH-1:0] dwell_cycles;
   logic                   target_valid;
   logic                   target_ready;
   logic                   abort;
   logic [GAIN_WIDTH-1:0]  dac_reg;
   logic                   dac_reg_valid_stb;
   logic                   dac_reg_updated_stb;
   logic [GAIN_WIDTH-1:0]  current_gain;
   logic                   busy;
   logic                   done_stb;
   logic                   timeout_err;

   modport master (
      output target_gain, step_size, dwell_cycles, target_valid, abort, dac_reg_updated_stb,
      input  target_ready, dac_reg, dac_reg_valid_stb, current_gain, busy, done_stb, timeout_err
   );

   modport slave (
      input  target_gain, step_size, dwell_cycles, target_valid, abort, dac_reg_updated_stb,
      output target_ready, dac_reg, dac_reg_valid_stb, current_gain, busy, done_stb, timeout_err
   );
endinterface

// File: rtl/dac_gain_ramp_ctrl.sv
// Slews the DAC gain toward a requested target in bounded steps, one step per
// acknowledged SPI update, with an optional dwell between steps.
module dac_gain_ramp_ctrl #(
   parameter int                    GAIN_WIDTH     = 8,
   parameter int                    STEP_WIDTH     = 8,
   parameter int                    DWELL_WIDTH    = 16,
   parameter int                    TIMEOUT_CYCLES = 4096,
   parameter logic [GAIN_WIDTH-1:0] INIT_GAIN      = '0
) (
   input logic                clk,
   input logic                rst_n,
   dac_gain_ramp_ctrl_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = (GAIN_WIDTH > STEP_WIDTH) ? GAIN_WIDTH : STEP_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DWELL} state_t;

   state_t                 state_q, state_d;
   logic [GAIN_WIDTH-1:0]  dac_reg_q, dac_reg_d;
   logic                   stb_q, stb_d;
   logic [GAIN_WIDTH-1:0]  cur_q, cur_d;
   logic [GAIN_WIDTH-1:0]  tgt_q, tgt_d;
   logic [STEP_WIDTH-1:0]  step_q, step_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic                   abort_pend_q, abort_pend_d;
   logic                   done_q, done_d;
   logic                   terr_q, terr_d;
   logic                   ready_en_q;
   logic                   abort_now;
   logic [GAIN_WIDTH-1:0]  ramp_next;

   // Step is clamped to the remaining distance, so the add/subtract never wraps.
   function automatic logic [GAIN_WIDTH-1:0] next_gain(
      input logic [GAIN_WIDTH-1:0] cur,
      input logic [GAIN_WIDTH-1:0] tgt,
      input logic [STEP_WIDTH-1:0] step
   );
      logic [CW-1:0]         diff;
      logic [CW-1:0]         stp;
      logic [GAIN_WIDTH-1:0] stp_g;
      diff  = (tgt >= cur) ? CW'(tgt - cur) : CW'(cur - tgt);
      stp   = CW'(step);
      stp_g = GAIN_WIDTH'(step);
      if (step == '0 || diff <= stp) begin
         return tgt;
      end else if (tgt > cur) begin
         return cur + stp_g;
      end else begin
         return cur - stp_g;
      end
   endfunction

   assign ramp_next = next_gain(dac_reg_q, tgt_q, step_q);
   assign abort_now = abort_pend_q | bus.abort;

   always_comb begin
      state_d      = state_q;
      dac_reg_d    = dac_reg_q;
      stb_d        = 1'b0;
      cur_d        = cur_q;
      tgt_d        = tgt_q;
      step_d       = step_q;
      dwell_d      = dwell_q;
      dwell_cnt_d  = dwell_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      abort_pend_d = 1'b0;
      done_d       = 1'b0;
      terr_d       = terr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.target_valid && ready_en_q) begin
               tgt_d   = bus.target_gain;
               step_d  = bus.step_size;
               dwell_d = bus.dwell_cycles;
               terr_d  = 1'b0;
               if (bus.target_gain == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  dac_reg_d = next_gain(cur_q, bus.target_gain, bus.step_size);
                  stb_d     = 1'b1;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            tmo_cnt_d = TW'(1);
            state_d   = bus.abort ? S_IDLE : S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // An ack in the final timeout cycle still counts.
            if (bus.dac_reg_updated_stb) begin
               cur_d = dac_reg_q;
               if (dac_reg_q == tgt_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (abort_now) begin
                  state_d = S_IDLE;
               end else if (dwell_q == '0) begin
                  dac_reg_d = ramp_next;
                  stb_d     = 1'b1;
                  state_d   = S_ISSUE;
               end else begin
                  dwell_cnt_d = DWELL_WIDTH'(1);
                  state_d     = S_DWELL;
               end
            end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               terr_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_cnt_d    = tmo_cnt_q + 1'b1;
               abort_pend_d = abort_now;
            end
         end
         S_DWELL: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (dwell_cnt_q == dwell_q) begin
               dac_reg_d = ramp_next;
               stb_d     = 1'b1;
               state_d   = S_ISSUE;
            end else begin
               dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dac_reg_q    <= INIT_GAIN;
         stb_q        <= 1'b0;
         cur_q        <= INIT_GAIN;
         tgt_q        <= INIT_GAIN;
         step_q       <= '0;
         dwell_q      <= '0;
         dwell_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         terr_q       <= 1'b0;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         dac_reg_q    <= dac_reg_d;
         stb_q        <= stb_d;
         cur_q        <= cur_d;
         tgt_q        <= tgt_d;
         step_q       <= step_d;
         dwell_q      <= dwell_d;
         dwell_cnt_q  <= dwell_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         terr_q       <= terr_d;
         ready_en_q   <= 1'b1;
      end
   end

   // Ready is held low for the first cycle after reset release.
   assign bus.target_ready      = ready_en_q && (state_q == S_IDLE);
   assign bus.busy              = (state_q != S_IDLE);
   assign bus.dac_reg           = dac_reg_q;
   assign bus.dac_reg_valid_stb = stb_q;
   assign bus.current_gain      = cur_q;
   assign bus.done_stb          = done_q;
   assign bus.timeout_err       = terr_q;
endmodule

// File: tb/tb_dac_gain_ramp_ctrl.sv
// Directed bench for dac_gain_ramp_ctrl: ramps, jumps, timeout, abort and
// asynchronous reset, with an auto-acking DAC model and strobe monitor.
module tb_dac_gain_ramp_ctrl;
   localparam int          TMO  = 16;
   localparam logic [7:0]  INIT = 8'h10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dac_gain_ramp_ctrl_if #(.GAIN_WIDTH(8), .STEP_WIDTH(8), .DWELL_WIDTH(16)) bus();

   dac_gain_ramp_ctrl #(
      .GAIN_WIDTH(8), .STEP_WIDTH(8), .DWELL_WIDTH(16),
      .TIMEOUT_CYCLES(TMO), .INIT_GAIN(INIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         checks_cnt = 0;
   int         fail_cnt   = 0;
   logic [7:0] stb_vals[$];
   int         stb_cyc[$];
   int         done_cnt   = 0;
   int         done_cyc   = -1;
   int         ack_delay  = 5;
   bit         ack_en     = 1'b1;
   int         ack_at     = -1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int stb_c(input int i);
      return (i < stb_cyc.size()) ? stb_cyc[i] : -1000;
   endfunction

   function automatic logic [31:0] stb_v(input int i);
      return (i < stb_vals.size()) ? {24'd0, stb_vals[i]} : 32'hDEAD;
   endfunction

   // DAC model: records strobes/done pulses and acks each strobe after ack_delay cycles.
   initial begin
      bus.dac_reg_updated_stb = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.dac_reg_valid_stb) begin
            stb_vals.push_back(bus.dac_reg);
            stb_cyc.push_back(cyc);
            if (ack_en) ack_at = cyc + ack_delay;
         end
         if (bus.done_stb) begin
            done_cnt++;
            done_cyc = cyc;
         end
         bus.dac_reg_updated_stb = (ack_at == cyc);
      end
   end

   task automatic clear_mon();
      stb_vals.delete();
      stb_cyc.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic request(input logic [7:0] tgt, input logic [7:0] stp, input logic [15:0] dw,
                          output int acc);
      @(negedge clk);
      bus.target_gain  = tgt;
      bus.step_size    = stp;
      bus.dwell_cycles = dw;
      bus.target_valid = 1'b1;
      check_val("ready_at_request", bus.target_ready, 1);
      acc = cyc;
      @(negedge clk);
      bus.target_valid = 1'b0;
      $display("TXN request target=%02h step=%02h dwell=%0d accept_cycle=%0d from_gain=%02h",
               tgt, stp, dw, acc, bus.current_gain);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_within_budget", bus.busy, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int acc;
      int s;
      int tmo_cyc;
      bus.target_gain  = '0;
      bus.step_size    = '0;
      bus.dwell_cycles = '0;
      bus.target_valid = 1'b0;
      bus.abort        = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_dac_reg", bus.dac_reg, INIT);
      check_val("rst_current_gain", bus.current_gain, INIT);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_stb", bus.dac_reg_valid_stb, 0);
      check_val("rst_done", bus.done_stb, 0);
      check_val("rst_timeout_err", bus.timeout_err, 0);
      check_val("rst_ready", bus.target_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("ready_after_release", bus.target_ready, 1);

      // 0x10 -> 0x40, step 0x10, dwell 3, ack 5 cycles after each strobe
      ack_delay = 5;
      clear_mon();
      request(8'h40, 8'h10, 16'd3, acc);
      check_val("t1_busy_after_accept", bus.busy, 1);
      check_val("t1_ready_after_accept", bus.target_ready, 0);
      wait_idle(100);
      check_val("t1_nstb", stb_vals.size(), 3);
      check_val("t1_v0", stb_v(0), 8'h20);
      check_val("t1_v1", stb_v(1), 8'h30);
      check_val("t1_v2", stb_v(2), 8'h40);
      check_val("t1_first_stb_cycle", stb_c(0) - acc, 1);
      check_val("t1_gap01", stb_c(1) - stb_c(0), 9);
      check_val("t1_gap12", stb_c(2) - stb_c(1), 9);
      check_val("t1_done_cnt", done_cnt, 1);
      check_val("t1_done_cycle", done_cyc - stb_c(2), 6);
      check_val("t1_current_gain", bus.current_gain, 8'h40);

      // 0x40 -> 0x05, step 0x10, dwell 0, ack after 2
      ack_delay = 2;
      clear_mon();
      request(8'h05, 8'h10, 16'd0, acc);
      wait_idle(100);
      check_val("t2_nstb", stb_vals.size(), 4);
      check_val("t2_v0", stb_v(0), 8'h30);
      check_val("t2_v1", stb_v(1), 8'h20);
      check_val("t2_v2", stb_v(2), 8'h10);
      check_val("t2_v3", stb_v(3), 8'h05);
      for (int i = 1; i < 4; i++) check_val($sformatf("t2_gap%0d", i), stb_c(i) - stb_c(i-1), 3);
      check_val("t2_done_cnt", done_cnt, 1);
      check_val("t2_current_gain", bus.current_gain, 8'h05);

      // Step 0 jumps straight to 0xFF
      clear_mon();
      request(8'hFF, 8'h00, 16'd7, acc);
      wait_idle(100);
      check_val("t3_nstb", stb_vals.size(), 1);
      check_val("t3_v0", stb_v(0), 8'hFF);
      check_val("t3_current_gain", bus.current_gain, 8'hFF);
      check_val("t3_done_cnt", done_cnt, 1);

      // Target equal to current gain: done next cycle, no strobe
      clear_mon();
      request(8'hFF, 8'h10, 16'd0, acc);
      check_val("t3b_done_next_cycle", bus.done_stb, 1);
      check_val("t3b_busy", bus.busy, 0);
      repeat (5) @(negedge clk);
      check_val("t3b_nstb", stb_vals.size(), 0);
      check_val("t3b_done_cnt", done_cnt, 1);

      // Never ack: timeout exactly TMO cycles after the strobe
      ack_en = 1'b0;
      clear_mon();
      request(8'h00, 8'h40, 16'd0, acc);
      s = cyc;
      check_val("t4_stb_now", bus.dac_reg_valid_stb, 1);
      check_val("t4_dac_reg", bus.dac_reg, 8'hBF);
      tmo_cyc = -1;
      for (int i = 0; i < 3 * TMO && tmo_cyc < 0; i++) begin
         @(negedge clk);
         if (bus.timeout_err) begin
            tmo_cyc = cyc;
            check_val("t4_idle_at_timeout", bus.busy, 0);
         end
      end
      check_val("t4_timeout_latency", tmo_cyc - s, TMO);
      check_val("t4_current_gain", bus.current_gain, 8'hFF);
      check_val("t4_dac_reg_held", bus.dac_reg, 8'hBF);
      ack_en = 1'b1;
      request(8'hFF, 8'h00, 16'd0, acc);
      check_val("t4_err_cleared", bus.timeout_err, 0);
      check_val("t4_done_equal", bus.done_stb, 1);

      // Back to 0x10, then abort during DWELL of a 0x10 -> 0x40 ramp
      ack_delay = 2;
      request(8'h10, 8'h00, 16'd0, acc);
      wait_idle(100);
      check_val("t5_setup_gain", bus.current_gain, 8'h10);
      ack_delay = 5;
      clear_mon();
      request(8'h40, 8'h10, 16'd3, acc);
      repeat (6) @(negedge clk);
      check_val("t5_in_dwell_busy", bus.busy, 1);
      check_val("t5_in_dwell_gain", bus.current_gain, 8'h20);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_val("t5_idle_after_abort", bus.busy, 0);
      check_val("t5_ready_after_abort", bus.target_ready, 1);
      repeat (20) @(negedge clk);
      check_val("t5_nstb", stb_vals.size(), 1);
      check_val("t5_done_cnt", done_cnt, 0);
      check_val("t5_current_gain", bus.current_gain, 8'h20);

      // Abort during WAIT_ACK: ack still consumed
      clear_mon();
      request(8'h60, 8'h10, 16'd0, acc);
      repeat (2) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      check_val("t6_still_waiting", bus.busy, 1);
      @(negedge clk);
      check_val("t6_idle_after_ack", bus.busy, 0);
      check_val("t6_current_gain", bus.current_gain, 8'h30);
      repeat (10) @(negedge clk);
      check_val("t6_nstb", stb_vals.size(), 1);
      check_val("t6_done_cnt", done_cnt, 0);

      // Async reset mid-WAIT_ACK, late ack ignored, then a fresh request
      ack_delay = 8;
      clear_mon();
      request(8'h50, 8'h10, 16'd0, acc);
      check_val("t7_dac_reg_issued", bus.dac_reg, 8'h40);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("t7_rst_dac_reg", bus.dac_reg, INIT);
      check_val("t7_rst_current_gain", bus.current_gain, INIT);
      check_val("t7_rst_busy", bus.busy, 0);
      check_val("t7_rst_ready", bus.target_ready, 0);
      check_val("t7_rst_stb", bus.dac_reg_valid_stb, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_val("t7_late_ack_ignored", bus.current_gain, INIT);
      check_val("t7_idle_after_reset", bus.busy, 0);
      check_val("t7_ready_after_reset", bus.target_ready, 1);
      ack_delay = 2;
      clear_mon();
      request(8'h20, 8'h00, 16'd0, acc);
      wait_idle(100);
      check_val("t7_new_nstb", stb_vals.size(), 1);
      check_val("t7_new_gain", bus.current_gain, 8'h20);
      check_val("t7_new_done_cnt", done_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation exceeded time bound at cycle %0d", cyc);
      $fatal(1, "time limit");
   end
endmodule
